// File: rtl/ahb_slave_fe.sv
// ahb_slave_fe: AHB-Lite slave front end for the AHB-to-APB bridge.
// Decodes the address phase into NUM_REGIONS equal windows, issues one
// valid/ready request per transfer and stalls the data phase with Hreadyout
// until the downstream response returns. Unmapped, oversize and misaligned
// transfers, and downstream errors, get the two-cycle AHB ERROR response.
// Optional build macro: AHB_POSTED_WR_EN -- writes complete on the request
// handshake and never wait for a downstream response.
module ahb_slave_fe #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGIONS = 4,
    parameter int                REGION_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [1:0]             Htrans,
    input  logic                   Hwrite,
    input  logic                   Hreadyin,
    input  logic [ADDR_W-1:0]      Haddr,
    input  logic [2:0]             Hburst,
    input  logic [2:0]             Hsize,
    input  logic [DATA_W-1:0]      Hwdata,
    output logic                   Hreadyout,
    output logic [1:0]             Hresp,
    output logic [DATA_W-1:0]      Hrdata,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_W-1:0]      req_addr,
    output logic                   req_write,
    output logic [2:0]             req_size,
    output logic [NUM_REGIONS-1:0] req_sel,
    output logic [DATA_W-1:0]      req_wdata,
    input  logic                   rsp_valid,
    input  logic [DATA_W-1:0]      rsp_rdata,
    input  logic                   rsp_err
);

    localparam int SEL_BITS = $clog2(NUM_REGIONS);
    localparam int RSEL_W   = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int TOP      = REGION_LOG2 + SEL_BITS;
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RSP, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t                  state, state_nx;
    logic                    hit, bad, accept, first_req;
    logic [NUM_REGIONS-1:0]  sel_dec;
    logic [ADDR_W-1:0]       amask;
    logic [DATA_W-1:0]       wdata_q;

    // Burst type and the NONSEQ/SEQ distinction carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{Hburst, Htrans[0]};

    // Window decode: upper bits pick the aperture, the next SEL_BITS pick the window.
    assign hit = (Haddr[ADDR_W-1:TOP] == BASE_ADDR[ADDR_W-1:TOP]);
    generate
        if (NUM_REGIONS > 1) begin : g_multi
            logic [RSEL_W-1:0] widx;
            assign widx    = Haddr[REGION_LOG2 +: RSEL_W];
            assign sel_dec = hit ? (NUM_REGIONS'(1) << widx) : '0;
        end else begin : g_single
            assign sel_dec = hit;
        end
    endgenerate

    // Transfer is flagged when unmapped, wider than the bus or misaligned.
    assign amask  = (ADDR_W'(1) << Hsize) - ADDR_W'(1);
    assign bad    = !hit || (Hsize > 3'(MAX_SIZE)) || ((Haddr & amask) != '0);
    assign accept = Hreadyin && Htrans[1] &&
                    (state == S_IDLE || state == S_DONE || state == S_ERR2);

    // Write data is only valid in the data phase, so it is forwarded live in
    // the first REQ cycle and held from the register afterwards.
    assign req_wdata = first_req ? Hwdata : wdata_q;

    // State register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state and bus/handshake outputs.
    always_comb begin
        state_nx  = state;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        req_valid = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (state == S_ERR2) Hresp = 2'b01;
                if (accept) state_nx = bad ? S_ERR1 : S_REQ;
                else        state_nx = S_IDLE;
            end
            S_REQ: begin
                Hreadyout = 1'b0;
                req_valid = 1'b1;
`ifdef AHB_POSTED_WR_EN
                if (req_ready) state_nx = req_write ? S_DONE : S_RSP;
`else
                if (req_ready) state_nx = S_RSP;
`endif
            end
            S_RSP: begin
                Hreadyout = 1'b0;
                if (rsp_valid) state_nx = rsp_err ? S_ERR1 : S_DONE;
            end
            S_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_nx  = S_ERR2;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address-phase capture and write-data hold.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_size  <= '0;
            req_sel   <= '0;
            wdata_q   <= '0;
            first_req <= 1'b0;
        end else begin
            first_req <= accept && !bad;
            if (accept) begin
                req_addr  <= Haddr;
                req_write <= Hwrite;
                req_size  <= Hsize;
                req_sel   <= sel_dec;
            end
            if (first_req) wdata_q <= Hwdata;
        end
    end

    // Read data register, loaded only by a read response in RSP.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)                                     Hrdata <= '0;
        else if (state == S_RSP && rsp_valid && !req_write) Hrdata <= rsp_rdata;
    end

endmodule

// File: tb/tb_ahb_slave_fe.sv
// Directed testbench for ahb_slave_fe (default parameters, DATA_W=32).
module tb_ahb_slave_fe;

    logic        Hclk, Hresetn;
    logic [1:0]  Htrans;
    logic        Hwrite, Hreadyin;
    logic [31:0] Haddr;
    logic [2:0]  Hburst, Hsize;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    ahb_slave_fe dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite),
        .Hreadyin(Hreadyin), .Haddr(Haddr), .Hburst(Hburst), .Hsize(Hsize),
        .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_sel(req_sel),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic phase(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        Htrans = tr; Hwrite = wr; Haddr = a; Hsize = sz; Hreadyin = 1'b1;
    endtask

    task automatic idle_bus();
        Htrans = 2'd0; Hwrite = 1'b0;
    endtask

    logic [31:0] ev_addr [3];
    logic [2:0]  ev_size [3];

    initial begin
        Hresetn = 1'b0; Htrans = 2'd0; Hwrite = 1'b0; Hreadyin = 1'b1;
        Haddr = '0; Hburst = 3'd0; Hsize = 3'd0; Hwdata = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        ev_addr[0] = 32'h9000_0000; ev_size[0] = 3'd2;
        ev_addr[1] = 32'h8000_0000; ev_size[1] = 3'd3;
        ev_addr[2] = 32'h8000_0002; ev_size[2] = 3'd2;

        // Reset state
        #2;
        chk("rst_hready", Hreadyout, 1);
        chk("rst_hresp", Hresp, 0);
        chk("rst_hrdata", Hrdata, 0);
        chk("rst_reqvalid", req_valid, 0);
        chk("rst_reqaddr", req_addr, 0);
        chk("rst_reqsel", req_sel, 0);
        chk("rst_reqwdata", req_wdata, 0);
        #10 Hresetn = 1'b1;

        // BUSY and a NONSEQ without Hreadyin are both ignored
        tick(); phase(2'd1, 1'b0, 32'h8000_1000, 3'd2); #1;
        tick(); Htrans = 2'd2; Hreadyin = 1'b0; #1;
        chk("busy_hready", Hreadyout, 1);
        chk("busy_reqaddr", req_addr, 0);
        tick(); idle_bus(); Hreadyin = 1'b1; #1;
        chk("noready_reqvalid", req_valid, 0);
        chk("noready_hready", Hreadyout, 1);

        // Read 0x8000_1004
        tick(); phase(2'd2, 1'b0, 32'h8000_1004, 3'd2); req_ready = 1'b1; #1;
        tick(); idle_bus(); #1;
        chk("rd_reqvalid", req_valid, 1);
        chk("rd_hready_req", Hreadyout, 0);
        chk("rd_reqsel", req_sel, 4'b0010);
        chk("rd_reqaddr", req_addr, 32'h8000_1004);
        chk("rd_reqwrite", req_write, 0);
        tick(); rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_hready_rsp", Hreadyout, 0);
        chk("rd_reqvalid_rsp", req_valid, 0);
        tick(); rsp_valid = 1'b0; #1;
        chk("rd_hready_done", Hreadyout, 1);
        chk("rd_hresp", Hresp, 0);
        chk("rd_hrdata", Hrdata, 32'hDEAD_BEEF);

        // Write 0x8000_3000 with req_ready low for 3 cycles
        tick(); phase(2'd2, 1'b1, 32'h8000_3000, 3'd2); req_ready = 1'b0; #1;
        tick(); idle_bus(); Hwdata = 32'h1234_5678; #1;
        for (int i = 0; i < 3; i++) begin
            chk("wr_stall_valid", req_valid, 1);
            chk("wr_stall_wdata", req_wdata, 32'h1234_5678);
            chk("wr_stall_addr", req_addr, 32'h8000_3000);
            chk("wr_stall_sel", req_sel, 4'b1000);
            chk("wr_stall_write", req_write, 1);
            chk("wr_stall_hready", Hreadyout, 0);
            tick(); Hwdata = 32'hA5A5_0000 + 32'(i); #1;
        end
        req_ready = 1'b1; #1;
        chk("wr_hs_valid", req_valid, 1);
        chk("wr_hs_wdata", req_wdata, 32'h1234_5678);
`ifndef AHB_POSTED_WR_EN
        tick(); rsp_valid = 1'b1; rsp_rdata = 32'h5555_5555; #1;
        chk("wr_rsp_hready", Hreadyout, 0);
`endif
        tick(); rsp_valid = 1'b0; #1;
        chk("wr_done_hready", Hreadyout, 1);
        chk("wr_done_hresp", Hresp, 0);
        chk("wr_hrdata_kept", Hrdata, 32'hDEAD_BEEF);

        // Error transfers, pipelined back to back through ERR2
        tick(); phase(2'd2, 1'b0, ev_addr[0], ev_size[0]); #1;
        for (int k = 0; k < 3; k++) begin
            tick(); idle_bus(); #1;
            chk("err1_hready", Hreadyout, 0);
            chk("err1_hresp", Hresp, 2'b01);
            chk("err1_reqvalid", req_valid, 0);
            tick();
            if (k < 2) phase(2'd2, 1'b0, ev_addr[k+1], ev_size[k+1]);
            #1;
            chk("err2_hready", Hreadyout, 1);
            chk("err2_hresp", Hresp, 2'b01);
            chk("err2_reqvalid", req_valid, 0);
        end

        // Back-to-back: NONSEQ read OK, SEQ read accepted in DONE gets rsp_err
        tick(); phase(2'd2, 1'b0, 32'h8000_0008, 3'd2); #1;
        chk("b2b_idle_hresp", Hresp, 0);
        tick(); idle_bus(); #1;
        chk("b2b1_reqvalid", req_valid, 1);
        tick(); rsp_valid = 1'b1; rsp_rdata = 32'h1111_2222; #1;
        tick(); rsp_valid = 1'b0; phase(2'd3, 1'b0, 32'h8000_000C, 3'd2); #1;
        chk("b2b1_hready", Hreadyout, 1);
        chk("b2b1_hresp", Hresp, 0);
        chk("b2b1_hrdata", Hrdata, 32'h1111_2222);
        tick(); idle_bus(); #1;
        chk("b2b2_reqvalid", req_valid, 1);
        chk("b2b2_reqaddr", req_addr, 32'h8000_000C);
        chk("b2b2_hready", Hreadyout, 0);
        tick(); rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h3333_4444; #1;
        chk("b2b2_rsp_hready", Hreadyout, 0);
        tick(); rsp_valid = 1'b0; rsp_err = 1'b0; #1;
        chk("b2b2_err1_hready", Hreadyout, 0);
        chk("b2b2_err1_hresp", Hresp, 2'b01);
        tick(); #1;
        chk("b2b2_err2_hready", Hreadyout, 1);
        chk("b2b2_err2_hresp", Hresp, 2'b01);

        // Reset asserted in RSP; an early response in REQ must not count
        tick(); phase(2'd2, 1'b0, 32'h8000_2000, 3'd2); #1;
        tick(); idle_bus(); rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_0BAD; #1;
        tick(); rsp_valid = 1'b0; #1;
        chk("early_rsp_ignored", Hreadyout, 0);
        Hresetn = 1'b0; #1;
        chk("async_rst_hready", Hreadyout, 1);
        chk("async_rst_hresp", Hresp, 0);
        chk("async_rst_reqvalid", req_valid, 0);
        chk("async_rst_reqaddr", req_addr, 0);
        chk("async_rst_hrdata", Hrdata, 0);
        #2 Hresetn = 1'b1;
        tick(); phase(2'd2, 1'b0, 32'h8000_2004, 3'd2); #1;
        tick(); idle_bus(); #1;
        chk("post_rst_reqsel", req_sel, 4'b0100);
        chk("post_rst_reqaddr", req_addr, 32'h8000_2004);
        tick(); rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D; #1;
        tick(); rsp_valid = 1'b0; #1;
        chk("post_rst_hready", Hreadyout, 1);
        chk("post_rst_hresp", Hresp, 0);
        chk("post_rst_hrdata", Hrdata, 32'hCAFE_F00D);

`ifdef AHB_POSTED_WR_EN
        // Posted write: DONE directly after REQ, responses ignored
        tick(); phase(2'd2, 1'b1, 32'h8000_0010, 3'd2); #1;
        tick(); idle_bus(); Hwdata = 32'h0F0F_0F0F; rsp_valid = 1'b1; rsp_err = 1'b1; #1;
        chk("pw_reqvalid", req_valid, 1);
        tick(); #1;
        chk("pw_done_hready", Hreadyout, 1);
        chk("pw_done_hresp", Hresp, 0);
        tick(); rsp_valid = 1'b0; rsp_err = 1'b0; #1;
        chk("pw_idle_hready", Hreadyout, 1);
        chk("pw_idle_hresp", Hresp, 0);
        chk("pw_hrdata_kept", Hrdata, 32'hCAFE_F00D);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
